// File: rtl/fir_coeff_loader.sv
// Coefficient bank plus reload sequencer that streams NUM_TAPS words into the FIR reload channel.
// Optional readback port: define FIR_COEFF_READBACK_EN.
module fir_coeff_loader #(
  parameter int NUM_TAPS = 16,
  parameter int COEFF_W  = 16,
  parameter int ADDR_W   = 6
) (
  input  logic               clkfir,
  input  logic               reset,
  input  logic               coeff_wen,
  input  logic [ADDR_W-1:0]  coeff_waddr,
  input  logic [COEFF_W-1:0] coeff_wdata,
  input  logic               reload_start,
  output logic               reload_valid,
  input  logic               reload_ready,
  output logic               reload_last,
  output logic [COEFF_W-1:0] reload_coeff,
  output logic               busy,
  output logic               done,
  output logic               wr_err
`ifdef FIR_COEFF_READBACK_EN
  ,
  input  logic [ADDR_W-1:0]  coeff_raddr,
  output logic [COEFF_W-1:0] coeff_rdata
`endif
);

  localparam int IDX_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_TAPS - 1);
  localparam logic [ADDR_W:0]   TAPS_EXT  = (ADDR_W + 1)'(NUM_TAPS);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   next_idx;
  logic [COEFF_W-1:0] bank [NUM_TAPS];

  logic               idle;
  logic               waddr_ok;
  logic               wr_accept;
  logic               start_accept;
  logic               rejects;
  logic [IDX_W-1:0]   widx;
  logic [COEFF_W-1:0] first_word;

  assign idle         = (state == S_IDLE);
  assign waddr_ok     = ({1'b0, coeff_waddr} < TAPS_EXT);
  assign wr_accept    = coeff_wen && idle && waddr_ok;
  assign start_accept = reload_start && idle;
  assign rejects      = (coeff_wen && !wr_accept) || (reload_start && !idle);
  assign widx         = coeff_waddr[IDX_W-1:0];
  assign next_idx     = idx + 1'b1;
  // A write landing on tap 0 in the start cycle must reach the first word.
  assign first_word   = (wr_accept && (widx == '0)) ? coeff_wdata : bank[0];

  always_ff @(posedge clkfir or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_TAPS; i++) bank[i] <= '0;
    end else if (wr_accept) begin
      bank[widx] <= coeff_wdata;
    end
  end

  always_ff @(posedge clkfir or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      idx          <= '0;
      reload_valid <= 1'b0;
      reload_last  <= 1'b0;
      reload_coeff <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      wr_err       <= 1'b0;
    end else begin
      done <= 1'b0;
      // An accepted start clears the sticky error, but a write rejected in the same cycle still counts.
      if (start_accept) begin
        wr_err <= rejects;
      end else if (rejects) begin
        wr_err <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (reload_start) begin
            state        <= S_STREAM;
            idx          <= '0;
            reload_coeff <= first_word;
            reload_valid <= 1'b1;
            reload_last  <= (NUM_TAPS == 1);
            busy         <= 1'b1;
          end
        end
        S_STREAM: begin
          if (reload_ready) begin
            if (idx == LAST_IDX) begin
              state        <= S_DONE;
              reload_valid <= 1'b0;
              reload_last  <= 1'b0;
              done         <= 1'b1;
            end else begin
              idx          <= next_idx;
              reload_coeff <= bank[next_idx];
              reload_last  <= (next_idx == LAST_IDX);
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef FIR_COEFF_READBACK_EN
  logic raddr_ok;
  assign raddr_ok = ({1'b0, coeff_raddr} < TAPS_EXT);

  always_ff @(posedge clkfir or posedge reset) begin
    if (reset) begin
      coeff_rdata <= '0;
    end else begin
      coeff_rdata <= raddr_ok ? bank[coeff_raddr[IDX_W-1:0]] : '0;
    end
  end
`endif

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Self-checking bench for fir_coeff_loader: directed packets, stalls, rejects, async reset, random traffic.
module tb_fir_coeff_loader;
  localparam int N = 16;

  logic        clkfir = 1'b0;
  logic        reset = 1'b1;
  logic        coeff_wen = 1'b0;
  logic [5:0]  coeff_waddr = '0;
  logic [15:0] coeff_wdata = '0;
  logic        reload_start = 1'b0;
  logic        reload_valid;
  logic        reload_ready = 1'b1;
  logic        reload_last;
  logic [15:0] reload_coeff;
  logic        busy;
  logic        done;
  logic        wr_err;
`ifdef FIR_COEFF_READBACK_EN
  logic [5:0]  coeff_raddr = '0;
  logic [15:0] coeff_rdata;
`endif

  fir_coeff_loader #(.NUM_TAPS(N), .COEFF_W(16), .ADDR_W(6)) dut (
    .clkfir(clkfir), .reset(reset),
    .coeff_wen(coeff_wen), .coeff_waddr(coeff_waddr), .coeff_wdata(coeff_wdata),
    .reload_start(reload_start), .reload_valid(reload_valid), .reload_ready(reload_ready),
    .reload_last(reload_last), .reload_coeff(reload_coeff),
    .busy(busy), .done(done), .wr_err(wr_err)
`ifdef FIR_COEFF_READBACK_EN
    , .coeff_raddr(coeff_raddr), .coeff_rdata(coeff_rdata)
`endif
  );

  always #5 clkfir = ~clkfir;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: m_pos = -1 idle, 0..N-1 word being offered, N = done cycle.
  int          m_pos = -1;
  logic [15:0] m_bank [N];
  logic [15:0] m_snap [N];
  logic        m_err = 1'b0;
  logic [15:0] m_rdata = '0;

  always @(posedge clkfir or posedge reset) begin
    if (reset) begin
      m_pos = -1;
      m_err = 1'b0;
      m_rdata = '0;
      for (int i = 0; i < N; i++) m_bank[i] = '0;
    end else begin
      bit idle, w_ok, rej;
      idle = (m_pos < 0);
      w_ok = coeff_wen && idle && (coeff_waddr < N);
      rej  = (coeff_wen && !w_ok) || (reload_start && !idle);
`ifdef FIR_COEFF_READBACK_EN
      m_rdata = (coeff_raddr < N) ? m_bank[coeff_raddr] : 16'h0;
`endif
      if (w_ok) m_bank[coeff_waddr] = coeff_wdata;
      if (reload_start && idle) begin
        m_snap = m_bank;
        m_pos  = 0;
        m_err  = rej;
      end else begin
        m_err = m_err | rej;
        if (m_pos >= 0 && m_pos < N) begin
          if (reload_ready) m_pos++;
        end else if (m_pos == N) begin
          m_pos = -1;
        end
      end
    end
  end

  // Ready driver: 0 = always high, 1 = pattern 1,0,0, 2 = random.
  int rdy_mode = 0;
  int rp = 0;
  always @(posedge clkfir) begin
    #1;
    case (rdy_mode)
      0: reload_ready = 1'b1;
      1: begin reload_ready = (rp % 3 == 0); rp++; end
      default: reload_ready = 1'($urandom_range(0, 1));
    endcase
  end

  logic [15:0] got [$];
  int          last_idx = -1;
  int          stalls = 0;

  always @(negedge clkfir) begin
    if (!reset) begin
      bit mv;
      mv = (m_pos >= 0 && m_pos < N);
      chk("valid", reload_valid, mv);
      chk("last", reload_last, (m_pos == N - 1));
      chk("busy", busy, (m_pos >= 0));
      chk("done", done, (m_pos == N));
      chk("wr_err", wr_err, m_err);
      if (mv) chk("coeff", reload_coeff, m_snap[m_pos]);
`ifdef FIR_COEFF_READBACK_EN
      chk("rdata", coeff_rdata, m_rdata);
`endif
      if (mv && !reload_ready) stalls++;
      if (reload_valid && reload_ready) begin
        got.push_back(reload_coeff);
        if (reload_last) last_idx = got.size() - 1;
      end
    end
  end

  task automatic tick();
    @(posedge clkfir);
    #1;
  endtask

  task automatic write(input logic [5:0] a, input logic [15:0] d);
    coeff_wen = 1'b1; coeff_waddr = a; coeff_wdata = d;
    tick();
    coeff_wen = 1'b0;
  endtask

  task automatic start();
    reload_start = 1'b1;
    tick();
    reload_start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clkfir);
      lat++;
      if (done) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL wait_done timeout actual=no_done required=done");
  endtask

  task automatic clear_capture();
    got.delete();
    last_idx = -1;
    stalls = 0;
  endtask

  initial begin
    int lat;
    int nz;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clkfir);
    chk("rst_valid", reload_valid, 1'b0);
    chk("rst_last", reload_last, 1'b0);
    chk("rst_coeff", reload_coeff, 16'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", wr_err, 1'b0);

    // Basic packet with ready held high
    tick();
    for (int i = 0; i < N; i++) write(6'(i), 16'h0100 + 16'(i));
    clear_capture();
    start();
    wait_done(lat);
    chk("t1_latency", lat, 32'd17);
    chk("t1_count", got.size(), 32'd16);
    for (int i = 0; i < got.size(); i++) chk("t1_word", got[i], 16'h0100 + 16'(i));
    chk("t1_last_idx", last_idx, 32'd15);
    chk("t1_err", wr_err, 1'b0);

    // Same packet with ready pattern 1,0,0
    tick();
    clear_capture();
    rp = 0;
    rdy_mode = 1;
    start();
    wait_done(lat);
    rdy_mode = 0;
    chk("t2_stalls_seen", (stalls > 0), 1'b1);
    chk("t2_latency", lat, 32'(17 + stalls));
    chk("t2_count", got.size(), 32'd16);
    for (int i = 0; i < got.size(); i++) chk("t2_word", got[i], 16'h0100 + 16'(i));

    // Out-of-range write, then start clears the error
    tick();
    write(6'd20, 16'h5555);
    @(negedge clkfir);
    chk("t3_err_set", wr_err, 1'b1);
    tick();
    clear_capture();
    start();
    @(negedge clkfir);
    chk("t3_err_clr", wr_err, 1'b0);
    wait_done(lat);
    chk("t3_count", got.size(), 32'd16);

    // Write and start while streaming are rejected
    tick();
    clear_capture();
    start();
    tick();
    coeff_wen = 1'b1; coeff_waddr = 6'd3; coeff_wdata = 16'hAAAA; reload_start = 1'b1;
    tick();
    coeff_wen = 1'b0; reload_start = 1'b0;
    wait_done(lat);
    chk("t4_word3", got[3], 16'h0103);
    chk("t4_err", wr_err, 1'b1);
    repeat (20) tick();
    @(negedge clkfir);
    chk("t4_no_second", busy, 1'b0);
    chk("t4_count", got.size(), 32'd16);

    // Async reset mid-packet, then a fresh packet of zeros
    tick();
    start();
    for (int i = 0; i < 50 && m_pos != 7; i++) @(negedge clkfir);
    reset = 1'b1;
    #1;
    chk("t5_valid", reload_valid, 1'b0);
    chk("t5_last", reload_last, 1'b0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_coeff", reload_coeff, 16'h0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    clear_capture();
    start();
    wait_done(lat);
    nz = 0;
    foreach (got[i]) if (got[i] != 16'h0) nz++;
    chk("t5_count", got.size(), 32'd16);
    chk("t5_zero_words", nz, 32'd0);

`ifdef FIR_COEFF_READBACK_EN
    tick();
    write(6'd5, 16'h1234);
    coeff_raddr = 6'd5;
    tick();
    @(negedge clkfir);
    chk("rb_addr5", coeff_rdata, 16'h1234);
    tick();
    coeff_raddr = 6'd40;
    tick();
    @(negedge clkfir);
    chk("rb_addr40", coeff_rdata, 16'h0);
`endif

    // Random traffic against the model
    tick();
    rdy_mode = 2;
    for (int i = 0; i < 2500; i++) begin
      coeff_wen    = ($urandom_range(0, 3) == 0);
      coeff_waddr  = 6'($urandom_range(0, 20));
      coeff_wdata  = 16'($urandom);
      reload_start = ($urandom_range(0, 19) == 0);
`ifdef FIR_COEFF_READBACK_EN
      coeff_raddr  = 6'($urandom_range(0, 40));
`endif
      tick();
    end
    coeff_wen = 1'b0;
    reload_start = 1'b0;
    rdy_mode = 0;
    for (int i = 0; i < 100 && m_pos >= 0; i++) tick();
    @(negedge clkfir);
    chk("final_idle", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_coeff_loader.md
# fir_coeff_loader

Coefficient reload sequencer sitting directly upstream of the FIR filter block. Host register writes load a local coefficient bank; on a start command the block streams the bank, in tap order, into the FIR core's reload channel using a valid/ready handshake and flags the final word with `reload_last`. While streaming, `reload_valid` is high, which also gates off FIR data sampling, so a reload never interleaves with sample traffic.

## Interface

- `NUM_TAPS`, 16: number of coefficients per reload packet, 2..64.
- `COEFF_W`, 16: coefficient width in bits; matches FIR reload data width.
- `ADDR_W`, 6: coefficient address width; must satisfy 2^ADDR_W ≥ NUM_TAPS.

- `clkfir`  in  1  FIR clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `coeff_wen`  in  1  host write strobe, one word per cycle.
- `coeff_waddr`  in  ADDR_W  tap index of write.
- `coeff_wdata`  in  COEFF_W  coefficient value.
- `reload_start`  in  1  single-cycle request to stream the bank.
- `reload_valid`  out  1  reload word valid (to FIR).
- `reload_ready`  in  1  FIR reload channel ready.
- `reload_last`  out  1  marks final word of packet.
- `reload_coeff`  out  COEFF_W  reload word.
- `busy`  out  1  high from accepted start until done.
- `done`  out  1  one-cycle pulse after final handshake.
- `wr_err`  out  1  sticky: write or start rejected while busy, or write address ≥ NUM_TAPS.

## Operation

- Bank: NUM_TAPS × COEFF_W registers, cleared to 0 by reset. Write in IDLE with `coeff_waddr < NUM_TAPS` updates the entry next edge; other writes are dropped and set `wr_err`.
- States: IDLE, STREAM, DONE.
- IDLE: `reload_start` → STREAM; load `idx=0`, `reload_coeff=bank[0]`, `reload_valid=1`, `reload_last=(NUM_TAPS==1)` (never, given NUM_TAPS ≥ 2), `busy=1`; clear `wr_err`. Write and start in the same cycle: write takes effect first, so the streamed packet includes it.
- STREAM: outputs held stable while `reload_ready=0`. On `reload_valid && reload_ready`: if `idx==NUM_TAPS-1` → DONE with `reload_valid=0`, `reload_last=0`; else `idx+1`, `reload_coeff=bank[idx+1]`, `reload_last=(idx+1==NUM_TAPS-1)`.
- DONE: `done=1` for one cycle, `busy=0` on exit → IDLE.
- `reload_start` outside IDLE is ignored and sets `wr_err`.
- Reset mid-packet: all state and outputs return to reset values immediately. A partial packet is abandoned; the FIR core reports missing tlast, which is its concern.

## Timing

- Reset values: `reload_valid=0`, `reload_last=0`, `reload_coeff=0`, `busy=0`, `done=0`, `wr_err=0`, state IDLE, `idx=0`.
- Start sampled at edge T: `reload_valid` and `busy` high after T; first word presented in cycle T+1.
- With `reload_ready` held high: one word per cycle. Words occupy T+1..T+NUM_TAPS, `reload_last` in cycle T+NUM_TAPS, `done` in T+NUM_TAPS+1, `busy` low from T+NUM_TAPS+2.
- Each stall cycle adds exactly one cycle. There is no combinational path from `reload_ready` to any output; all outputs are registered.

## Configuration

- `FIR_COEFF_READBACK_EN` defined: adds ports `coeff_raddr` (in, ADDR_W) and `coeff_rdata` (out, COEFF_W). `coeff_rdata` is registered `bank[coeff_raddr]` with one-cycle latency, 0 for out-of-range addresses, and remains valid in any state.
- Undefined: these ports and their logic are absent. Behaviour is otherwise identical.

## Test plan

- Reset, write bank[i]=0x0100+i for i=0..15, pulse start, ready high → words 0x0100..0x010F in consecutive cycles, `last` only on 0x010F, `done` one cycle later, `wr_err=0`.
- Same packet with ready toggling 1,0,0,1… → identical word sequence, outputs stable during stalls, `done` delayed by the number of stall cycles.
- Write to addr 20 in IDLE → bank unchanged, `wr_err=1`. Then start → `wr_err` cleared, packet streams.
- Write bank[3]=0xAAAA and pulse start during STREAM → write dropped, packet still shows the old bank[3], `wr_err=1`, no second packet.
- Assert reset at word 7 → `reload_valid`, `reload_last`, `busy` go low asynchronously and bank reads 0. A fresh start streams 16 zeros.
- With `FIR_COEFF_READBACK_EN`: write 0x1234 to addr 5, set `coeff_raddr=5` → `coeff_rdata=0x1234` one cycle later. Addr 40 → 0.
